// File: rtl/ibm_pkg.sv
// Shared types and GF(2^M) helpers for the folded inversionless Berlekamp-Massey engine.
package ibm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned GF_MAX_W = 16;

  // Iteration counter must hold r up to 2T.
  function automatic int unsigned cnt_width(input int unsigned t);
    return $clog2(2 * t + 1);
  endfunction

  // Polynomial-basis multiply; poly carries the reduction bits below x^m.
  function automatic logic [GF_MAX_W-1:0] gf_mul(input logic [GF_MAX_W-1:0] a,
                                                 input logic [GF_MAX_W-1:0] b,
                                                 input int unsigned        m,
                                                 input logic [GF_MAX_W-1:0] poly);
    logic [GF_MAX_W-1:0] acc;
    logic [GF_MAX_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < GF_MAX_W; i++) begin
      if (i < m) begin
        if (b[i]) acc ^= sh;
        if (sh[m-1]) sh = (sh << 1) ^ poly;
        else         sh = sh << 1;
      end
    end
    return acc;
  endfunction

  // Index of the highest set bit of a nonzero-coefficient mask.
  function automatic int unsigned poly_deg(input logic [31:0] nz);
    int unsigned d;
    d = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (nz[i]) d = i;
    end
    return d;
  endfunction

endpackage

// File: rtl/ibm_iter_lane.sv
// One coefficient lane: holds sigma_j and B_j and applies the broadcast iBM update.
module ibm_iter_lane
  import ibm_pkg::*;
#(
  parameter int unsigned M        = 10,
  parameter logic [M:0]  POLY     = 11'h409,
  parameter bit          INIT_ONE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_upd,
  input  logic [M-1:0] i_delta,
  input  logic [M-1:0] i_gamma,
  input  logic [M-1:0] i_b_lo,
  input  logic [M-1:0] i_b_load,
  input  logic [M-1:0] i_b_shift,
  output logic [M-1:0] o_sigma,
  output logic [M-1:0] o_b,
  output logic [M-1:0] o_sigma_upd_c
);

  logic [M-1:0] sigma_q, sigma_d;
  logic [M-1:0] b_q, b_d;

  // sigma_j' = gamma*sigma_j ^ delta*B_(j-1)
  always_comb begin
    o_sigma_upd_c = M'(gf_mul(16'(i_gamma), 16'(sigma_q), M, 16'(POLY)))
                  ^ M'(gf_mul(16'(i_delta), 16'(i_b_lo), M, 16'(POLY)));
  end

  always_comb begin
    sigma_d = sigma_q;
    b_d     = b_q;
    if (i_load) begin
      sigma_d = M'(INIT_ONE);
      b_d     = M'(INIT_ONE);
    end else if (i_step) begin
      sigma_d = o_sigma_upd_c;
      b_d     = i_upd ? i_b_load : i_b_shift;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sigma_q <= '0;
      b_q     <= '0;
    end else begin
      sigma_q <= sigma_d;
      b_q     <= b_d;
    end
  end

  assign o_sigma = sigma_q;
  assign o_b     = b_q;

endmodule

// File: rtl/ibm_iter.sv
// Folded inversionless Berlekamp-Massey: one iteration per cycle over T+1 lanes.
// Define IBM_BINARY_EN for the binary-BCH variant (T iterations, r stepping by 2).
module ibm_iter
  import ibm_pkg::*;
#(
  parameter int unsigned M    = 10,
  parameter int unsigned T    = 4,
  parameter logic [M:0]  POLY = 11'h409
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2*T*M-1:0]       i_syn,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [(T+1)*M-1:0]     o_sigma,
  output logic [$clog2(T+1):0]   o_deg,
  output logic                   o_fail,
  output logic                   o_busy
);

  localparam int unsigned SW = 2 * T * M;
  localparam int unsigned NL = T + 1;
  localparam int unsigned DW = $clog2(T + 1) + 1;
  localparam int unsigned RW = cnt_width(T);
`ifdef IBM_BINARY_EN
  localparam int unsigned R_STEP = 2;
  localparam int unsigned R_LAST = 2 * T - 2;
`else
  localparam int unsigned R_STEP = 1;
  localparam int unsigned R_LAST = 2 * T - 1;
`endif

  state_e          state_q, state_d;
  logic [SW-1:0]   syn_q, syn_d;
  logic [RW-1:0]   r_q, r_d;
  logic [DW-1:0]   l_q, l_d;
  logic [M-1:0]    gamma_q, gamma_d;
  logic            ready_q, ready_d, valid_q, valid_d;
  logic            busy_q, busy_d, fail_q, fail_d;

  logic            load_c, step_c, upd_c;
  logic [M-1:0]    delta_c;
  logic [DW-1:0]   deg_c;
  logic [31:0]     nz_c;
  int              idx_c;

  logic [M-1:0] sigma_lane [NL];
  logic [M-1:0] b_lane     [NL];
  logic [M-1:0] sigma_upd  [NL];
  logic [M-1:0] b_lo       [NL];
  logic [M-1:0] b_load     [NL];
  logic [M-1:0] b_shift    [NL];

  for (genvar j = 0; j < NL; j++) begin : g_lane
    if (j == 0) begin : g_lo0
      assign b_lo[j] = '0;
    end else begin : g_lon
      assign b_lo[j] = b_lane[j-1];
    end
`ifdef IBM_BINARY_EN
    if (j == 0) begin : g_ld0
      assign b_load[j] = '0;
    end else begin : g_ldn
      assign b_load[j] = sigma_lane[j-1];
    end
    if (j < 2) begin : g_sh0
      assign b_shift[j] = '0;
    end else begin : g_shn
      assign b_shift[j] = b_lane[j-2];
    end
`else
    assign b_load[j]  = sigma_lane[j];
    assign b_shift[j] = b_lo[j];
`endif

    ibm_iter_lane #(.M(M), .POLY(POLY), .INIT_ONE(j == 0)) u_lane (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load       (load_c),
      .i_step       (step_c),
      .i_upd        (upd_c),
      .i_delta      (delta_c),
      .i_gamma      (gamma_q),
      .i_b_lo       (b_lo[j]),
      .i_b_load     (b_load[j]),
      .i_b_shift    (b_shift[j]),
      .o_sigma      (sigma_lane[j]),
      .o_b          (b_lane[j]),
      .o_sigma_upd_c(sigma_upd[j])
    );

    assign o_sigma[j*M +: M] = sigma_lane[j];
  end

  // Discrepancy: XOR over sigma_j * S(r+1-j), skipping indices below 1.
  always_comb begin
    delta_c = '0;
    idx_c   = 0;
    for (int j = 0; j < int'(NL); j++) begin
      idx_c = int'(r_q) + 1 - j;
      if (idx_c >= 1) begin
        delta_c ^= M'(gf_mul(16'(sigma_lane[j]), 16'(syn_q[(idx_c-1)*M +: M]), M, 16'(POLY)));
      end
    end
  end

  assign upd_c = (delta_c != '0) && ((32'(l_q) << 1) <= 32'(r_q));

  // Degree of the sigma that the current step would produce.
  always_comb begin
    nz_c = '0;
    for (int j = 0; j < int'(NL); j++) begin
      nz_c[j] = (sigma_upd[j] != '0);
    end
    deg_c = DW'(poly_deg(nz_c));
  end

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    r_d     = r_q;
    l_d     = l_q;
    gamma_d = gamma_q;
    fail_d  = fail_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          syn_d   = i_syn;
          load_c  = 1'b1;
          r_d     = '0;
          l_d     = '0;
          gamma_d = M'(1);
          fail_d  = 1'b0;
          state_d = (i_syn == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (upd_c) begin
          l_d     = DW'(32'(r_q) + 32'd1 - 32'(l_q));
          gamma_d = delta_c;
        end
        if (r_q == RW'(R_LAST)) begin
          state_d = ST_DONE;
          fail_d  = (l_d > DW'(T)) || (deg_c != l_d);
        end else begin
          r_d = r_q + RW'(R_STEP);
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      syn_q   <= '0;
      r_q     <= '0;
      l_q     <= '0;
      gamma_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      r_q     <= r_d;
      l_q     <= l_d;
      gamma_q <= gamma_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_deg   = l_q;
  assign o_fail  = fail_q;

endmodule

// File: tb/tb_ibm_iter.sv
// Scoreboard bench for ibm_iter at M=4, T=2, POLY=x^4+x+1 (honours IBM_BINARY_EN).
module tb_ibm_iter;

  localparam int M      = 4;
  localparam int T      = 2;
  localparam int POLY_I = 'h13;
  localparam int SW     = 2 * T * M;
  localparam int OW     = (T + 1) * M;
  localparam int DW     = $clog2(T + 1) + 1;
`ifdef IBM_BINARY_EN
  localparam int STEP = 2;
  localparam int LAT  = T + 1;
`else
  localparam int STEP = 1;
  localparam int LAT  = 2 * T + 1;
`endif

  typedef struct {
    logic [OW-1:0] sigma;
    logic [DW-1:0] deg;
    logic          fail;
    int            lat;
  } exp_t;

  logic          clk, rst;
  logic          i_valid, o_ready, o_valid, i_ready;
  logic [SW-1:0] i_syn;
  logic [OW-1:0] o_sigma;
  logic [DW-1:0] o_deg;
  logic          o_fail, o_busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  ibm_iter #(.M(M), .T(T), .POLY(5'h13)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_syn  (i_syn),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sigma(o_sigma),
    .o_deg  (o_deg),
    .o_fail (o_fail),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  function automatic int tb_mul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < M; i++) if (b[i]) p ^= a << i;
    for (int i = 2 * M - 2; i >= M; i--) if (p[i]) p ^= POLY_I << (i - M);
    return p;
  endfunction

  // Reference iBM on plain integer arrays.
  function automatic exp_t model(input logic [SW-1:0] syn);
    int s[2*T+1];
    int sg[T+1], bb[T+1], nsg[T+1], nbb[T+1];
    int l, g, d, dg;
    bit nz;
    exp_t e;
    nz = 0;
    s[0] = 0;
    for (int i = 1; i <= 2 * T; i++) begin
      s[i] = int'(syn[(i-1)*M +: M]);
      if (s[i] != 0) nz = 1;
    end
    for (int j = 0; j <= T; j++) begin
      sg[j] = (j == 0) ? 1 : 0;
      bb[j] = sg[j];
    end
    l = 0;
    g = 1;
    if (nz) begin
      for (int r = 0; r < 2 * T; r += STEP) begin
        d = 0;
        for (int j = 0; j <= T; j++) if (r + 1 - j >= 1) d ^= tb_mul(sg[j], s[r+1-j]);
        for (int j = 0; j <= T; j++) nsg[j] = tb_mul(g, sg[j]) ^ ((j > 0) ? tb_mul(d, bb[j-1]) : 0);
        if (d != 0 && 2 * l <= r) begin
`ifdef IBM_BINARY_EN
          for (int j = 0; j <= T; j++) nbb[j] = (j > 0) ? sg[j-1] : 0;
`else
          for (int j = 0; j <= T; j++) nbb[j] = sg[j];
`endif
          l = r + 1 - l;
          g = d;
        end else begin
`ifdef IBM_BINARY_EN
          for (int j = 0; j <= T; j++) nbb[j] = (j > 1) ? bb[j-2] : 0;
`else
          for (int j = 0; j <= T; j++) nbb[j] = (j > 0) ? bb[j-1] : 0;
`endif
        end
        sg = nsg;
        bb = nbb;
      end
    end
    dg = 0;
    for (int j = 0; j <= T; j++) if (sg[j] != 0) dg = j;
    e.sigma = '0;
    for (int j = 0; j <= T; j++) e.sigma[j*M +: M] = M'(sg[j]);
    e.deg  = DW'(l);
    e.fail = (l > T) || (dg != l);
    e.lat  = nz ? LAT : 1;
    return e;
  endfunction

  task automatic send(input logic [SW-1:0] syn);
    i_syn   = syn;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (o_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (o_valid !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_busy  !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_sigma !== '0)   begin bad++; $display("FAIL reset_sigma: got %h want 0", o_sigma); end
    total++; if (o_deg   !== '0)   begin bad++; $display("FAIL reset_deg: got %0d want 0", o_deg); end
    total++; if (o_fail  !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", o_fail); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc;
    i_ready = 1'b0;
    sb.push_back(model(16'hFAC8));
    send(16'hFAC8);
    wait_valid(cyc);
    e = sb.pop_front();
    total++; if (cyc !== e.lat)     begin bad++; $display("FAIL bp_latency: got %0d want %0d", cyc, e.lat); end
    total++; if (o_deg !== e.deg)   begin bad++; $display("FAIL bp_deg: got %0d want %0d", o_deg, e.deg); end
    total++; if (o_fail !== e.fail) begin bad++; $display("FAIL bp_fail: got %b want %b", o_fail, e.fail); end
    for (int k = 0; k < 7; k++) begin
      total++; if (o_valid !== 1'b1)   begin bad++; $display("FAIL bp_hold_valid%0d: got %b want 1", k, o_valid); end
      total++; if (o_sigma !== e.sigma) begin bad++; $display("FAIL bp_hold_sigma%0d: got %h want %h", k, o_sigma, e.sigma); end
      total++; if (o_ready !== 1'b0)   begin bad++; $display("FAIL bp_hold_ready%0d: got %b want 0", k, o_ready); end
      total++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL bp_hold_busy%0d: got %b want 0", k, o_busy); end
      i_syn   = 16'h1234;
      i_valid = 1'b1;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
    @(negedge clk);
    total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL bp_no_capture: got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_mid_reset();
    send(16'hFAC8);
`ifdef IBM_BINARY_EN
    @(negedge clk);
`else
    repeat (2) @(negedge clk);
`endif
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", o_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", o_ready); end
    total++; if (o_busy !== 1'b0)  begin bad++; $display("FAIL mid_busy_clr: got %b want 0", o_busy); end
    total++; if (o_sigma !== '0)   begin bad++; $display("FAIL mid_sigma: got %h want 0", o_sigma); end
  endtask

  task automatic test_known();
    logic [SW-1:0] syn_tab [3];
    exp_t          tab [3];
    exp_t          e;
    int            cyc;
    syn_tab[0] = 16'h0000;
    syn_tab[1] = 16'hFAC8;
    syn_tab[2] = 16'h0001;
    tab[0] = '{sigma: 12'h001, deg: 3'd0, fail: 1'b0, lat: 1};
`ifdef IBM_BINARY_EN
    tab[1] = '{sigma: 12'h0C8, deg: 3'd1, fail: 1'b0, lat: LAT};
    tab[2] = '{sigma: 12'h011, deg: 3'd1, fail: 1'b0, lat: LAT};
`else
    tab[1] = '{sigma: 12'h0FA, deg: 3'd1, fail: 1'b0, lat: LAT};
    tab[2] = '{sigma: 12'h001, deg: 3'd1, fail: 1'b1, lat: LAT};
`endif
    for (int k = 0; k < 3; k++) begin
      sb.push_back(tab[k]);
      send(syn_tab[k]);
      wait_valid(cyc);
      e = sb.pop_front();
      total++; if (cyc !== e.lat)       begin bad++; $display("FAIL known%0d_latency: got %0d want %0d", k, cyc, e.lat); end
      total++; if (o_sigma !== e.sigma) begin bad++; $display("FAIL known%0d_sigma: got %h want %h", k, o_sigma, e.sigma); end
      total++; if (o_deg !== e.deg)     begin bad++; $display("FAIL known%0d_deg: got %0d want %0d", k, o_deg, e.deg); end
      total++; if (o_fail !== e.fail)   begin bad++; $display("FAIL known%0d_fail: got %b want %b", k, o_fail, e.fail); end
      @(negedge clk);
      total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        bad++; $display("FAIL known%0d_return: got valid=%b ready=%b want 0 1", k, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] syn;
    exp_t          e;
    int            cyc;
    for (int k = 0; k < 8; k++) begin
      syn = SW'($urandom);
      sb.push_back(model(syn));
      send(syn);
      wait_valid(cyc);
      e = sb.pop_front();
      total++; if (cyc !== e.lat)       begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", k, cyc, e.lat); end
      total++; if (o_sigma !== e.sigma) begin bad++; $display("FAIL rand%0d_sigma syn=%h: got %h want %h", k, syn, o_sigma, e.sigma); end
      total++; if (o_deg !== e.deg)     begin bad++; $display("FAIL rand%0d_deg syn=%h: got %0d want %0d", k, syn, o_deg, e.deg); end
      total++; if (o_fail !== e.fail)   begin bad++; $display("FAIL rand%0d_fail syn=%h: got %b want %b", k, syn, o_fail, e.fail); end
      @(negedge clk);
    end
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_syn   = '0;
    test_reset();
    test_backpressure();
    test_mid_reset();
    test_known();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
